verificacion_secuencia: RTL
===========================

Name: verificacion_secuencia

Overview:
Parametrised successor to the calculator's key-verification stage. It sits between the keypad translator and the operand memory/ALU and runs the full entry sequence: operand A, operator, operand B, equals. Out-of-sequence keys are filtered, each operand is limited to a fixed number of digits, operators are latched, and registered single-cycle strobes go to memory and the ALU.

Parameters:
CODE_W, 4, width of translated key code (>=4); digit codes are 0..9.
MAX_DIGITS, 4, maximum digits accepted per operand (1..15).
COD_SUMA, 4'hF, add operator code (zero-extended to CODE_W).
COD_RESTA, 4'hE, subtract operator code.
COD_IGUAL, 4'hD, equals code.
COD_BORRAR, 4'hC, clear code.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
tecla_valida  in  1  one-cycle strobe: numero_traducido holds a new key.
numero_traducido  in  CODE_W  translated key code.
salida  out  CODE_W  accepted digit, registered; holds its value between accepts.
enable_memoria  out  1  one-cycle write strobe for salida into the operand selected by sel_operando.
sel_operando  out  1  0 = operand A, 1 = operand B.
operador  out  CODE_W  latched operator code.
op_valido  out  1  one-cycle pulse: operador updated.
calcular  out  1  one-cycle pulse: start the ALU.
limpiar  out  1  one-cycle pulse: clear operand memories.
rechazo  out  1  one-cycle pulse: key rejected.
cuenta_digitos  out  $clog2(MAX_DIGITS+1)  digits accepted in the current operand.
estado  out  3  current FSM state, for debug and display.

Behaviour:
- Reset (asynchronous, any time, including mid-entry): state ESPERA_A, all outputs 0, operador = 0, count = 0.
- All outputs are registered. A strobe in cycle N produces its response in cycle N+1. Pulses last exactly 1 cycle.
- Each tecla_valida cycle is one key. Back-to-back strobes are processed independently. Cycles without tecla_valida change nothing except deasserting pulses.
- Key classes: digit (0..9), operator (SUMA/RESTA), IGUAL, BORRAR, and other (always rechazo, no state change).
- BORRAR in any state: limpiar, count = 0, operador = 0, sel_operando = 0, next state ESPERA_A.
- States (estado encoding 0..4):
  - ESPERA_A: digit -> salida = key, enable_memoria, count = 1, go to CARGA_A (or ESPERA_OP if MAX_DIGITS = 1). Operator or IGUAL -> rechazo.
  - CARGA_A: digit -> accept, count++; on reaching MAX_DIGITS go to ESPERA_OP. Operator -> operador = key, op_valido, count = 0, sel_operando = 1, go to CARGA_B. IGUAL -> rechazo.
  - ESPERA_OP: digit -> rechazo, enable_memoria stays 0. Operator -> same as in CARGA_A. IGUAL -> rechazo.
  - CARGA_B: digit with count < MAX_DIGITS -> accept, count++. Digit at MAX_DIGITS -> rechazo, stay. Operator with count = 0 -> replaces operador, op_valido. Operator with count > 0 -> rechazo. IGUAL with count > 0 -> calcular, go to RESULTADO. IGUAL with count = 0 -> rechazo.
  - RESULTADO: digit -> limpiar and enable_memoria in the same cycle, salida = key, count = 1, sel_operando = 0, go to CARGA_A. Operator -> chain on the result: operador = key, op_valido, count = 0, sel_operando = 1, go to CARGA_B. IGUAL -> calcular again (repeat operation).
- Count saturates at MAX_DIGITS and never wraps.
- Illegal estado encodings (5..7) recover to ESPERA_A on the next clock, with no output pulses.

Decomposition:
- Shared package calc_pkg:
  - state enum: ESPERA_A, CARGA_A, ESPERA_OP, CARGA_B, RESULTADO;
  - default key-code constants;
  - key-class enum.
- One natural sub-module: clasificador_tecla. It is combinational and maps a code to its key class using the code parameters.

Test Plan:
- Reset, then keys 3, 4, F, 2, D -> salida 3 then 4 with enable_memoria at sel 0; operador = F with op_valido; 2 written at sel 1; calcular pulses once; estado ends at RESULTADO.
- MAX_DIGITS = 4; keys 1, 2, 3, 4, 5 -> the first four are accepted, estado = ESPERA_OP after the 4th, the 5th gives rechazo and enable_memoria stays 0.
- At ESPERA_A, keys F then D then A -> three rechazo pulses, estado unchanged, no enable_memoria.
- Keys 7, F, E, 1 -> op_valido twice, final operador = E; a further E after 1 gives rechazo.
- Keys 5, F, 6, D, then E, 2, D -> chained operation: op_valido for E, sel 1, calcular pulses twice in total.
- Keys 9, F, 8, then rst_n low for half a cycle mid-stream -> all outputs 0 immediately and estado = ESPERA_A. Keys 9, F, 8, then C -> limpiar and estado = ESPERA_A.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and default key codes for the calculator key-sequencing stage.
package calc_pkg;

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    CARGA_A   = 3'd1,
    ESPERA_OP = 3'd2,
    CARGA_B   = 3'd3,
    RESULTADO = 3'd4
  } estado_t;

  typedef enum logic [2:0] {
    CLASE_DIGITO,
    CLASE_OPERADOR,
    CLASE_IGUAL,
    CLASE_BORRAR,
    CLASE_OTRA
  } clase_t;

  localparam logic [3:0] COD_SUMA_DEF   = 4'hF;
  localparam logic [3:0] COD_RESTA_DEF  = 4'hE;
  localparam logic [3:0] COD_IGUAL_DEF  = 4'hD;
  localparam logic [3:0] COD_BORRAR_DEF = 4'hC;

endpackage

// File: rtl/clasificador_tecla.sv
// Combinational key classifier: maps a translated key code onto its key class.
module clasificador_tecla
  import calc_pkg::*;
#(
  parameter int         CODE_W     = 4,
  parameter logic [3:0] COD_SUMA   = COD_SUMA_DEF,
  parameter logic [3:0] COD_RESTA  = COD_RESTA_DEF,
  parameter logic [3:0] COD_IGUAL  = COD_IGUAL_DEF,
  parameter logic [3:0] COD_BORRAR = COD_BORRAR_DEF
) (
  input  logic [CODE_W-1:0] codigo,
  output clase_t            clase
);

  always_comb begin
    clase = CLASE_OTRA;
    if (codigo < CODE_W'(10))
      clase = CLASE_DIGITO;
    else if (codigo == CODE_W'(COD_SUMA) || codigo == CODE_W'(COD_RESTA))
      clase = CLASE_OPERADOR;
    else if (codigo == CODE_W'(COD_IGUAL))
      clase = CLASE_IGUAL;
    else if (codigo == CODE_W'(COD_BORRAR))
      clase = CLASE_BORRAR;
  end

endmodule

// File: rtl/verificacion_secuencia.sv
// Entry sequencer: operand A, operator, operand B, equals. Filters keys and
// issues registered single-cycle strobes toward the operand memory and ALU.
module verificacion_secuencia
  import calc_pkg::*;
#(
  parameter int         CODE_W     = 4,
  parameter int         MAX_DIGITS = 4,
  parameter logic [3:0] COD_SUMA   = COD_SUMA_DEF,
  parameter logic [3:0] COD_RESTA  = COD_RESTA_DEF,
  parameter logic [3:0] COD_IGUAL  = COD_IGUAL_DEF,
  parameter logic [3:0] COD_BORRAR = COD_BORRAR_DEF,
  localparam int        CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tecla_valida,
  input  logic [CODE_W-1:0] numero_traducido,
  output logic [CODE_W-1:0] salida,
  output logic              enable_memoria,
  output logic              sel_operando,
  output logic [CODE_W-1:0] operador,
  output logic              op_valido,
  output logic              calcular,
  output logic              limpiar,
  output logic              rechazo,
  output logic [CNT_W-1:0]  cuenta_digitos,
  output logic [2:0]        estado
);

  // Handshake: tecla_valida is a single-cycle qualifier with no back-pressure;
  // every cycle it is high carries exactly one key, answered in the next cycle.

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam estado_t TRAS_PRIMER_DIGITO = (MAX_DIGITS == 1) ? ESPERA_OP : CARGA_A;

  estado_t estado_q;
  clase_t  clase;
  logic [CNT_W-1:0] cuenta_mas_uno;

  assign estado         = estado_q;
  assign cuenta_mas_uno = cuenta_digitos + CNT_W'(1);

  clasificador_tecla #(
    .CODE_W     (CODE_W),
    .COD_SUMA   (COD_SUMA),
    .COD_RESTA  (COD_RESTA),
    .COD_IGUAL  (COD_IGUAL),
    .COD_BORRAR (COD_BORRAR)
  ) u_clasificador (
    .codigo (numero_traducido),
    .clase  (clase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= ESPERA_A;
      salida         <= '0;
      enable_memoria <= 1'b0;
      sel_operando   <= 1'b0;
      operador       <= '0;
      op_valido      <= 1'b0;
      calcular       <= 1'b0;
      limpiar        <= 1'b0;
      rechazo        <= 1'b0;
      cuenta_digitos <= '0;
    end else begin
      enable_memoria <= 1'b0;
      op_valido      <= 1'b0;
      calcular       <= 1'b0;
      limpiar        <= 1'b0;
      rechazo        <= 1'b0;

      case (estado_q)
        ESPERA_A, CARGA_A, ESPERA_OP, CARGA_B, RESULTADO: begin
          if (tecla_valida) begin
            case (clase)
              CLASE_BORRAR: begin
                limpiar        <= 1'b1;
                cuenta_digitos <= '0;
                operador       <= '0;
                sel_operando   <= 1'b0;
                estado_q       <= ESPERA_A;
              end

              CLASE_DIGITO: begin
                case (estado_q)
                  ESPERA_A: begin
                    salida         <= numero_traducido;
                    enable_memoria <= 1'b1;
                    cuenta_digitos <= CNT_W'(1);
                    estado_q       <= TRAS_PRIMER_DIGITO;
                  end
                  CARGA_A: begin
                    salida         <= numero_traducido;
                    enable_memoria <= 1'b1;
                    cuenta_digitos <= cuenta_mas_uno;
                    if (cuenta_mas_uno == CNT_MAX) estado_q <= ESPERA_OP;
                  end
                  CARGA_B: begin
                    if (cuenta_digitos < CNT_MAX) begin
                      salida         <= numero_traducido;
                      enable_memoria <= 1'b1;
                      cuenta_digitos <= cuenta_mas_uno;
                    end else begin
                      rechazo <= 1'b1;
                    end
                  end
                  RESULTADO: begin
                    // A new digit after a result starts a fresh calculation.
                    limpiar        <= 1'b1;
                    salida         <= numero_traducido;
                    enable_memoria <= 1'b1;
                    cuenta_digitos <= CNT_W'(1);
                    sel_operando   <= 1'b0;
                    estado_q       <= TRAS_PRIMER_DIGITO;
                  end
                  default: rechazo <= 1'b1;
                endcase
              end

              CLASE_OPERADOR: begin
                case (estado_q)
                  ESPERA_A: rechazo <= 1'b1;
                  CARGA_B: begin
                    if (cuenta_digitos == '0) begin
                      operador  <= numero_traducido;
                      op_valido <= 1'b1;
                    end else begin
                      rechazo <= 1'b1;
                    end
                  end
                  default: begin
                    operador       <= numero_traducido;
                    op_valido      <= 1'b1;
                    cuenta_digitos <= '0;
                    sel_operando   <= 1'b1;
                    estado_q       <= CARGA_B;
                  end
                endcase
              end

              CLASE_IGUAL: begin
                if (estado_q == CARGA_B && cuenta_digitos != '0) begin
                  calcular <= 1'b1;
                  estado_q <= RESULTADO;
                end else if (estado_q == RESULTADO) begin
                  calcular <= 1'b1;
                end else begin
                  rechazo <= 1'b1;
                end
              end

              default: rechazo <= 1'b1;
            endcase
          end
        end

        default: estado_q <= ESPERA_A;
      endcase
    end
  end

endmodule
